// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run in the
// background while busy stalls the pipeline. MTHI/MTLO update HI/LO in the
// accept cycle without stalling. A flush cancels the in-flight operation.
module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // The MUL count runs MUL_LAT-1 down to 0, i.e. MUL_LAT cycles in MUL.
    localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
    // 32 restoring-division iterations, counted 31 down to 0.
    localparam logic [5:0] DIV_CNT_INIT = 6'd31;

    // Unsigned magnitude of a value; 0x80000000 maps onto itself.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            abs32 = 32'd0 - v;
        end else begin
            abs32 = v;
        end
    endfunction

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        if (neg) begin
            neg_if = 32'd0 - v;
        end else begin
            neg_if = v;
        end
    endfunction

    state_e      state_q,      state_d;
    logic [5:0]  cnt_q,        cnt_d;
    // opa holds the multiplicand, or the dividend magnitude which is shifted
    // out MSB-first while quotient bits are shifted in at the bottom.
    logic [31:0] opa_q,        opa_d;
    logic [31:0] opb_q,        opb_d;
    logic [31:0] rem_q,        rem_d;
    logic        is_div_q,     is_div_d;
    logic        mul_signed_q, mul_signed_d;
    logic        q_neg_q,      q_neg_d;
    logic        r_neg_q,      r_neg_d;
    logic [31:0] hi_q,         hi_d;
    logic [31:0] lo_q,         lo_d;

    logic        accept_s;
    logic        div_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    assign accept_s     = op_valid & ~flush & (state_q == ST_IDLE);
    assign div_signed_s = (op == OP_DIV);

    // Sign/zero extension to 64 bits makes one truncated multiply cover both
    // MULT and MULTU without carries beyond bit 63.
    assign mul_a_s   = {{32{mul_signed_q & opa_q[31]}}, opa_q};
    assign mul_b_s   = {{32{mul_signed_q & opb_q[31]}}, opb_q};
    assign product_s = mul_a_s * mul_b_s;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    // diff_s[32] set means the trial went negative and is discarded.
    assign rem_shift_s = {rem_q, opa_q[31]};
    assign diff_s      = rem_shift_s - {1'b0, opb_q};

    assign quo_fix_s = neg_if(opa_q, q_neg_q);
    assign rem_fix_s = neg_if(rem_q, r_neg_q);

    assign busy = (state_q != ST_IDLE) | (op_valid & ~flush & ~op[2]);
    assign done = (state_q == ST_FINISH) & ~flush;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rem_d        = rem_q;
        is_div_d     = is_div_q;
        mul_signed_d = mul_signed_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_d        = src_a;
                            opb_d        = src_b;
                            is_div_d     = 1'b0;
                            mul_signed_d = (op == OP_MULT);
                            cnt_d        = MUL_CNT_INIT;
                            state_d      = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_d    = abs32(src_a, div_signed_s);
                            opb_d    = abs32(src_b, div_signed_s);
                            rem_d    = 32'd0;
                            is_div_d = 1'b1;
                            // Divide by zero keeps the all-ones quotient the
                            // iterations produce, so no quotient negation.
                            q_neg_d  = div_signed_s & (src_a[31] ^ src_b[31])
                                       & (src_b != 32'd0);
                            r_neg_d  = div_signed_s & src_a[31];
                            cnt_d    = DIV_CNT_INIT;
                            state_d  = ST_DIV;
                        end
                        OP_MTHI: begin
                            hi_d = src_a;
                        end
                        OP_MTLO: begin
                            lo_d = src_a;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 6'd0) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (diff_s[32]) begin
                        rem_d = rem_shift_s[31:0];
                    end else begin
                        rem_d = diff_s[31:0];
                    end
                    opa_d = {opa_q[30:0], ~diff_s[32]};
                    if (cnt_q == 6'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (flush) begin
                    hi_d = hi_q;
                end else if (is_div_q) begin
                    lo_d = quo_fix_s;
                    hi_d = rem_fix_s;
                end else begin
                    hi_d = product_s[63:32];
                    lo_d = product_s[31:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and HI/LO registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 6'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            rem_q        <= 32'd0;
            is_div_q     <= 1'b0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rem_q        <= rem_d;
            is_div_q     <= is_div_d;
            mul_signed_q <= mul_signed_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes reference results, a
// monitor pops and compares whenever done pulses.
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: architectural results from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb_v, q, r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (o)
            3'd0: begin
                q = sa * sb_v;
                ref_res = 64'(q);
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                ref_res = p;
            end
            3'd2: begin
                if (b == 32'd0) ref_res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb_v;
                    r = sa % sb_v;
                    ref_res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) ref_res = {a, 32'hFFFFFFFF};
                else ref_res = {a % b, a / b};
            end
            default: ref_res = {model_hi, model_lo};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: pick = 32'd0;
            1: pick = 32'hFFFFFFFF;
            2: pick = 32'h80000000;
            3: pick = 32'($urandom_range(1, 20));
            4: pick = 32'h7FFFFFFF;
            default: pick = $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    done_cnt++;
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    @(posedge clk);
                    #1;
                    chk("result_hi", 64'(hi), 64'(e.hi));
                    chk("result_lo", 64'(lo), 64'(e.lo));
                end
            end
        end
    end

    // Wait (bounded) for busy to fall; it must fall in the expected cycle.
    task automatic wait_idle(input int exp_drop);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_drop_cycle", 64'(cyc), 64'(exp_drop));
    endtask

    // Issue one op; optionally throw an ignored MULT at the DUT mid-flight.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit intrude);
        exp_t        e;
        logic [63:0] r;
        int          t0;
        int          lat;
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        t0       = cyc;
        lat      = (o < 3'd2) ? MUL_LAT + 1 : DIV_LAT;
        #1;
        chk("busy_issue", 64'(busy), 64'(o < 3'd4));
        if (o < 3'd4) begin
            r     = ref_res(o, a, b);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.cyc = t0 + lat;
            sb.push_back(e);
            model_hi = r[63:32];
            model_lo = r[31:0];
        end else if (o == 3'd4) begin
            model_hi = a;
        end else if (o == 3'd5) begin
            model_lo = a;
        end else begin
            model_hi = model_hi;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (o >= 3'd4) begin
            chk("mt_hi", 64'(hi), 64'(model_hi));
            chk("mt_lo", 64'(lo), 64'(model_lo));
            chk("mt_busy", 64'(busy), 64'd0);
        end else begin
            if (intrude) begin
                repeat (4) @(posedge clk);
                #1;
                op_valid = 1'b1;
                op       = 3'd0;
                src_a    = $urandom;
                src_b    = $urandom;
                @(posedge clk);
                #1;
                op_valid = 1'b0;
            end
            wait_idle(t0 + lat + 1);
        end
    endtask

    initial begin
        int dc;
        int t0;
        logic [2:0] ro;
        resetn   = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Multiplies
        issue(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        // Divides and corner cases
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(3'd3, 32'd9, 32'd0, 1'b0);
        issue(3'd2, 32'hFFFFFFF7, 32'd0, 1'b0);

        // Flush mid-divide: no done, HI/LO preserved
        issue(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0);
        issue(3'd5, 32'd1, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = 3'd2;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        dc    = done_cnt;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_done", 64'(done_cnt), 64'(dc));
        chk("flush_hi", 64'(hi), 64'hA5A5A5A5);
        chk("flush_lo", 64'(lo), 64'd1);

        // MULT issued while DIV runs is ignored
        issue(3'd2, 32'h12345678, 32'hFFFFF001, 1'b1);

        // Flush together with MTLO in IDLE: nothing accepted
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = 3'd5;
        src_a    = 32'hDEADBEEF;
        flush    = 1'b1;
        #1;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_idle_lo", 64'(lo), 64'(model_lo));

        // Async reset at cycle 20 of a divide
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = 3'd3;
        src_a    = 32'd77;
        src_b    = 32'd5;
        t0       = cyc;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        issue(3'd3, 32'd1000000, 32'd37, 1'b0);

        // Randomized mix, including ignored op codes 6/7
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, pick(), pick(), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
